// File: rtl/tero_group_sequencer.sv
// TERO group evaluation sequencer: walks PAR_CH-wide loop groups and averages 2**rep_log2 windows.
// Optional per-channel dead-loop flags (resp_dead) when TERO_GRP_DEAD_LOOP_EN is defined.
module tero_group_sequencer #(
  parameter int unsigned NUM_LOOPS      = 8,
  parameter int unsigned PAR_CH         = 2,
  parameter int unsigned CNT_BITS       = 16,
  parameter int unsigned REP_MAX_LOG2   = 12,
  parameter int unsigned EVAL_BITS      = 16,
  parameter int unsigned CHALLENGE_BITS = 4,
  localparam int unsigned NGRP          = NUM_LOOPS / PAR_CH,
  localparam int unsigned GRP_W         = $clog2(NGRP) + 1,
  localparam int unsigned REP_W         = $clog2(REP_MAX_LOG2 + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [CHALLENGE_BITS-1:0]    challenge,
  input  logic [REP_W-1:0]             rep_log2,
  input  logic [EVAL_BITS-1:0]         eval_cycles,
  input  logic [PAR_CH*CNT_BITS-1:0]   osc_cnt,
  output logic                         reset_puf,
  output logic                         enable_puf,
  output logic [GRP_W-1:0]             select_grp,
  output logic                         busy,
  output logic                         done,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [GRP_W-1:0]             resp_grp,
  output logic [PAR_CH*CNT_BITS-1:0]   resp_data
`ifdef TERO_GRP_DEAD_LOOP_EN
  ,
  output logic [PAR_CH-1:0]            resp_dead
`endif
);

  localparam int unsigned ACC_W = CNT_BITS + REP_MAX_LOG2;
  localparam int unsigned RC_W  = REP_MAX_LOG2 + 1;

  typedef enum logic [2:0] {StIdle, StInit, StEval, StSample, StOut, StNext, StDone} state_e;

  state_e               state_q, state_d;
  logic [REP_W-1:0]     rep_log2_q;
  logic [EVAL_BITS-1:0] eval_q, ev_cnt_q;
  logic [RC_W-1:0]      rep_cnt_q;
  logic [GRP_W-1:0]     grp_q, k_q;
  logic [ACC_W-1:0]     acc_q [PAR_CH];
  logic [ACC_W-1:0]     avg [PAR_CH];
  logic                 abort_q;
`ifdef TERO_GRP_DEAD_LOOP_EN
  logic [PAR_CH-1:0]    dead_q;
`endif

  logic             run_abort, ev_last, rep_last, k_last;
  logic [31:0]      chal_ext;
  logic [GRP_W-1:0] grp_start, grp_inc;

  assign run_abort = abort && (state_q != StIdle) && (state_q != StDone);
  assign ev_last   = (ev_cnt_q == eval_q - 1'b1);
  assign rep_last  = ((rep_cnt_q + 1'b1) == (RC_W'(1) << rep_log2_q));
  assign k_last    = ((k_q + 1'b1) == GRP_W'(NGRP));
  assign chal_ext  = 32'(challenge);
  assign grp_start = GRP_W'(chal_ext % NGRP);
  assign grp_inc   = (grp_q == GRP_W'(NGRP - 1)) ? '0 : grp_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StInit;
      StInit:   state_d = StEval;
      StEval:   if (ev_last) state_d = StSample;
      StSample: state_d = rep_last ? StOut : StInit;
      StOut:    if (resp_ready) state_d = StNext;
      StNext:   state_d = k_last ? StDone : StInit;
      StDone:   if (!start) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // Abort overrides everything, including a same-cycle response transfer.
    if (run_abort) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_log2_q <= '0;
      eval_q     <= '0;
      ev_cnt_q   <= '0;
      rep_cnt_q  <= '0;
      grp_q      <= '0;
      k_q        <= '0;
      abort_q    <= 1'b0;
      for (int c = 0; c < PAR_CH; c++) acc_q[c] <= '0;
`ifdef TERO_GRP_DEAD_LOOP_EN
      dead_q     <= '0;
`endif
    end else begin
      abort_q <= run_abort;
      case (state_q)
        StIdle: if (start) begin
          rep_log2_q <= (rep_log2 > REP_W'(REP_MAX_LOG2)) ? REP_W'(REP_MAX_LOG2) : rep_log2;
          eval_q     <= (eval_cycles == '0) ? EVAL_BITS'(1) : eval_cycles;
          grp_q      <= grp_start;
          k_q        <= '0;
          rep_cnt_q  <= '0;
          for (int c = 0; c < PAR_CH; c++) acc_q[c] <= '0;
`ifdef TERO_GRP_DEAD_LOOP_EN
          dead_q     <= '0;
`endif
        end
        StInit: ev_cnt_q <= '0;
        StEval: ev_cnt_q <= ev_cnt_q + 1'b1;
        StSample: begin
          rep_cnt_q <= rep_cnt_q + 1'b1;
          for (int c = 0; c < PAR_CH; c++) begin
            acc_q[c] <= acc_q[c] + ACC_W'(osc_cnt[c*CNT_BITS +: CNT_BITS]);
`ifdef TERO_GRP_DEAD_LOOP_EN
            if (osc_cnt[c*CNT_BITS +: CNT_BITS] == '0) dead_q[c] <= 1'b1;
`endif
          end
        end
        StNext: begin
          k_q <= k_q + 1'b1;
          if (!k_last) begin
            grp_q     <= grp_inc;
            rep_cnt_q <= '0;
            for (int c = 0; c < PAR_CH; c++) acc_q[c] <= '0;
`ifdef TERO_GRP_DEAD_LOOP_EN
            dead_q    <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    reset_puf  = reset || (state_q == StInit) || abort_q;
    enable_puf = (state_q == StEval);
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    resp_valid = (state_q == StOut);
    select_grp = grp_q;
    resp_grp   = grp_q;
    resp_data  = '0;
    for (int c = 0; c < PAR_CH; c++) begin
      avg[c] = acc_q[c] >> rep_log2_q;
      resp_data[c*CNT_BITS +: CNT_BITS] = (|avg[c][ACC_W-1:CNT_BITS]) ? {CNT_BITS{1'b1}}
                                                                       : avg[c][CNT_BITS-1:0];
    end
  end

`ifdef TERO_GRP_DEAD_LOOP_EN
  assign resp_dead = dead_q;
`endif

endmodule

// File: tb/tb_tero_group_sequencer.sv
// Scoreboard bench for tero_group_sequencer; define TERO_GRP_DEAD_LOOP_EN to also cover resp_dead.
module tb_tero_group_sequencer;
  localparam int unsigned GRP_W = 3;
  localparam int unsigned DW    = 32;

  typedef struct packed {
    logic [GRP_W-1:0] grp;
    logic [DW-1:0]    data;
  } resp_t;

  logic          clk = 1'b0;
  logic          reset, start, abort, resp_ready;
  logic [3:0]    challenge, rep_log2;
  logic [15:0]   eval_cycles;
  logic [DW-1:0] osc_cnt = '0;
  logic          reset_puf, enable_puf, busy, done, resp_valid;
  logic [GRP_W-1:0] select_grp, resp_grp;
  logic [DW-1:0] resp_data;
`ifdef TERO_GRP_DEAD_LOOP_EN
  logic [1:0]    resp_dead;
`endif

  resp_t       exp_q[$];
  resp_t       mon_e;
  int          xfer_cyc[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          idx = 0;
  logic [15:0] seq0 [4];
  logic [15:0] seq1 [4];

  tero_group_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .challenge   (challenge),
    .rep_log2    (rep_log2),
    .eval_cycles (eval_cycles),
    .osc_cnt     (osc_cnt),
    .reset_puf   (reset_puf),
    .enable_puf  (enable_puf),
    .select_grp  (select_grp),
    .busy        (busy),
    .done        (done),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_grp    (resp_grp),
    .resp_data   (resp_data)
`ifdef TERO_GRP_DEAD_LOOP_EN
    ,
    .resp_dead   (resp_dead)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter model: a fresh per-rep count pair is presented on every INIT pulse.
  always @(negedge clk) begin
    if (!busy) idx <= 0;
    else if (reset_puf) begin
      osc_cnt <= {seq1[idx], seq0[idx]};
      idx     <= (idx + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (resp_valid === 1'b1 && resp_ready === 1'b1 && abort === 1'b0 && reset === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp got grp=%0d data=%h required no response", resp_grp,
                 resp_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (resp_grp !== mon_e.grp || resp_data !== mon_e.data) begin
          failures++;
          $display("FAIL resp got grp=%0d data=%h required grp=%0d data=%h", resp_grp,
                   resp_data, mon_e.grp, mon_e.data);
        end
      end
      xfer_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fixed(input logic [15:0] c0, input logic [15:0] c1);
    for (int i = 0; i < 4; i++) begin
      seq0[i] = c0;
      seq1[i] = c1;
    end
  endtask

  task automatic push_run(input int first, input logic [DW-1:0] data);
    resp_t e;
    for (int i = 0; i < 4; i++) begin
      e.grp  = GRP_W'((first + i) % 4);
      e.data = data;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_timeout got done=%b required 1", name, done);
    end
  endtask

  task automatic check_drained(input string name, input int xfers);
    checks++;
    if (exp_q.size() != 0 || xfer_cyc.size() != xfers) begin
      failures++;
      $display("FAIL %s_drain got pending=%0d xfers=%0d required pending=0 xfers=%0d", name,
               exp_q.size(), xfer_cyc.size(), xfers);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if ({reset_puf, enable_puf, busy, done, resp_valid, select_grp, resp_grp, resp_data}
        !== {1'b1, 4'b0, 3'd0, 3'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_outputs got puf=%b en=%b busy=%b done=%b vld=%b data=%h required 1/0",
               reset_puf, enable_puf, busy, done, resp_valid, resp_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (reset_puf !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got puf=%b busy=%b required 0 0", reset_puf, busy);
    end
  endtask

  task automatic test_basic();
    int c1;
    set_fixed(16'd100, 16'd200);
    challenge = 4'd0; rep_log2 = 4'd2; eval_cycles = 16'd4; resp_ready = 1'b1;
    push_run(0, {16'd200, 16'd100});
    xfer_cyc.delete();
    start = 1'b1;
    tick();
    c1 = cyc;
    // Mid-run input changes must not disturb the latched configuration.
    challenge = 4'd3; rep_log2 = 4'd5; eval_cycles = 16'd9;
    wait_done("basic", 400);
    check_drained("basic", 4);
    if (xfer_cyc.size() == 4) begin
      checks++;
      if (xfer_cyc[0] - c1 != 24) begin
        failures++;
        $display("FAIL basic_first_latency got %0d required 24", xfer_cyc[0] - c1);
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (xfer_cyc[i] - xfer_cyc[i-1] != 26) begin
          failures++;
          $display("FAIL basic_spacing got %0d required 26", xfer_cyc[i] - xfer_cyc[i-1]);
        end
      end
    end
    start = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle got done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_challenge();
    set_fixed(16'd7, 16'hffff);
    challenge = 4'd6; rep_log2 = 4'd2; eval_cycles = 16'd1; resp_ready = 1'b1;
    push_run(2, {16'hffff, 16'd7});
    xfer_cyc.delete();
    start = 1'b1;
    wait_done("challenge", 400);
    check_drained("challenge", 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || reset_puf !== 1'b0) begin
        failures++;
        $display("FAIL challenge_done_hold got done=%b busy=%b puf=%b required 1 1 0", done,
                 busy, reset_puf);
      end
    end
    start = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL challenge_idle got done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_vary();
    int s0 = 0;
    int s1 = 0;
    seq0[0] = 16'd10; seq0[1] = 16'd11; seq0[2] = 16'd12; seq0[3] = 16'd13;
    seq1[0] = 16'd1;  seq1[1] = 16'd2;  seq1[2] = 16'd3;  seq1[3] = 16'd5;
    for (int i = 0; i < 4; i++) begin
      s0 += int'(seq0[i]);
      s1 += int'(seq1[i]);
    end
    challenge = 4'd1; rep_log2 = 4'd2; eval_cycles = 16'd2; resp_ready = 1'b1;
    push_run(1, {16'(s1 >> 2), 16'(s0 >> 2)});
    xfer_cyc.delete();
    start = 1'b1;
    wait_done("vary", 400);
    check_drained("vary", 4);
    start = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int n = 0;
    set_fixed(16'd300, 16'd400);
    challenge = 4'd0; rep_log2 = 4'd1; eval_cycles = 16'd3; resp_ready = 1'b0;
    push_run(0, {16'd400, 16'd300});
    xfer_cyc.delete();
    start = 1'b1;
    while (resp_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({resp_valid, resp_grp, resp_data, enable_puf, reset_puf}
          !== {1'b1, 3'd0, 16'd400, 16'd300, 2'b00}) begin
        failures++;
        $display("FAIL stall_hold got vld=%b grp=%0d data=%h en=%b puf=%b required 1 0 %h 0 0",
                 resp_valid, resp_grp, resp_data, enable_puf, reset_puf, {16'd400, 16'd300});
      end
    end
    resp_ready = 1'b1;
    wait_done("stall", 400);
    check_drained("stall", 4);
    start = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int n = 0;
    resp_t e;
    set_fixed(16'd1, 16'd2);
    challenge = 4'd0; rep_log2 = 4'd0; eval_cycles = 16'd3; resp_ready = 1'b1;
    e.grp = 3'd0; e.data = {16'd2, 16'd1};
    exp_q.push_back(e);
    xfer_cyc.delete();
    start = 1'b1;
    while (!(select_grp === 3'd1 && enable_puf === 1'b1) && n < 200) begin
      tick();
      n++;
    end
    abort = 1'b1; start = 1'b0;
    tick();
    checks++;
    if ({busy, reset_puf, done, resp_valid, enable_puf} !== 5'b01000) begin
      failures++;
      $display("FAIL abort_eval got busy=%b puf=%b done=%b vld=%b en=%b required 0 1 0 0 0",
               busy, reset_puf, done, resp_valid, enable_puf);
    end
    abort = 1'b0;
    tick();
    checks++;
    if (reset_puf !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_puf_once got puf=%b busy=%b required 0 0", reset_puf, busy);
    end
    check_drained("abort_eval", 1);
    // Abort together with a handshake: nothing is transferred.
    resp_ready = 1'b0; start = 1'b1;
    n = 0;
    while (resp_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    abort = 1'b1; resp_ready = 1'b1; start = 1'b0;
    tick();
    abort = 1'b0; resp_ready = 1'b0;
    checks++;
    if ({busy, reset_puf, done, resp_valid} !== 4'b0100) begin
      failures++;
      $display("FAIL abort_xfer got busy=%b puf=%b done=%b vld=%b required 0 1 0 0", busy,
               reset_puf, done, resp_valid);
    end
    tick();
    check_drained("abort_xfer", 1);
  endtask

  task automatic test_big_reps();
    int n = 0;
    int en = 0;
    resp_t e;
    set_fixed(16'd5, 16'd9);
    challenge = 4'd1; rep_log2 = 4'd15; eval_cycles = 16'd0; resp_ready = 1'b0;
    e.grp = 3'd1; e.data = {16'd9, 16'd5};
    exp_q.push_back(e);
    xfer_cyc.delete();
    start = 1'b1;
    tick();
    while (resp_valid !== 1'b1 && n < 13000) begin
      if (enable_puf === 1'b1) en++;
      tick();
      n++;
    end
    checks++;
    if (en != 4096 || n != 3 * 4096) begin
      failures++;
      $display("FAIL big_reps got enables=%0d cycles=%0d required 4096 12288", en, n);
    end
    resp_ready = 1'b1;
    tick();
    abort = 1'b1; start = 1'b0; resp_ready = 1'b0;
    tick();
    abort = 1'b0;
    tick();
    check_drained("big_reps", 1);
  endtask

`ifdef TERO_GRP_DEAD_LOOP_EN
  task automatic test_dead_loop();
    int n = 0;
    resp_t e;
    seq0[0] = 16'd4; seq0[1] = 16'd4; seq0[2] = 16'd4; seq0[3] = 16'd4;
    seq1[0] = 16'd3; seq1[1] = 16'd0; seq1[2] = 16'd3; seq1[3] = 16'd3;
    challenge = 4'd0; rep_log2 = 4'd2; eval_cycles = 16'd1; resp_ready = 1'b0;
    e.grp = 3'd0; e.data = {16'd2, 16'd4};
    exp_q.push_back(e);
    xfer_cyc.delete();
    start = 1'b1;
    while (resp_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (resp_dead !== 2'b10) begin
      failures++;
      $display("FAIL dead_loop got %b required 10", resp_dead);
    end
    resp_ready = 1'b1;
    tick();
    abort = 1'b1; start = 1'b0; resp_ready = 1'b0;
    tick();
    abort = 1'b0;
    tick();
    check_drained("dead_loop", 1);
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; resp_ready = 1'b0;
    challenge = '0; rep_log2 = '0; eval_cycles = '0;
    set_fixed(16'd0, 16'd0);
    tick();
    test_reset();
    test_basic();
    test_challenge();
    test_vary();
    test_backpressure();
    test_abort();
    test_big_reps();
`ifdef TERO_GRP_DEAD_LOOP_EN
    test_dead_loop();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
